// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that shares one APB master among NREQ requesters: it
// captures one request, drives the master's command inputs, and returns done/err/rdata.
module apb_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 33,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               pclk,
  input  logic               preset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    req_grant,
  output logic [NREQ-1:0]    req_done,
  output logic               req_err,
  output logic [DW-1:0]      req_rdata,
  output logic               transfer,
  output logic               Read_write,
  output logic [AW-1:0]      write_addr,
  output logic [AW-1:0]      read_addr,
  output logic [DW-1:0]      write_data,
  input  logic               psel,
  input  logic               penable,
  input  logic               pready,
  input  logic [DW-1:0]      readOut,
  input  logic               PSlavErr
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] XFER = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [7:0]      TLIM     = 8'(TIMEOUT - 1);
  localparam logic [LW-1:0]   LAST_RST = LW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

  logic [1:0]    state;
  logic [LW-1:0] last;
  logic [7:0]    tcnt;

  logic          any_req;
  logic [LW-1:0] win;
  logic [LW-1:0] cand;
  logic          cmpl;
  logic          finish_xfer;

  // Search starts just above the last winner and wraps, so a sole requester
  // equal to last is found on the final step and regranted.
  always_comb begin
    any_req = 1'b0;
    win     = last;
    cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = LW'((int'(last) + k) % NREQ);
      if (!any_req && req_valid[cand]) begin
        any_req = 1'b1;
        win     = cand;
      end
    end
  end

  assign cmpl        = psel & penable & pready;
  assign finish_xfer = cmpl | PSlavErr | (tcnt == TLIM);

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state      <= IDLE;
      last       <= LAST_RST;
      tcnt       <= '0;
      req_grant  <= '0;
      req_done   <= '0;
      req_err    <= 1'b0;
      req_rdata  <= '0;
      transfer   <= 1'b0;
      Read_write <= 1'b0;
      write_addr <= '0;
      read_addr  <= '0;
      write_data <= '0;
    end else begin
      req_done <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state      <= XFER;
            last       <= win;
            tcnt       <= '0;
            req_grant  <= ONE_HOT0 << win;
            transfer   <= 1'b1;
            Read_write <= req_write[win];
            write_addr <= req_addr[win*AW +: AW];
            read_addr  <= req_addr[win*AW +: AW];
            write_data <= req_write[win] ? req_wdata[win*DW +: DW] : '0;
          end
        end
        XFER: begin
          tcnt <= tcnt + 8'd1;
          // Completion takes precedence over timeout; a slave error always flags err.
          if (finish_xfer) begin
            state     <= DONE;
            transfer  <= 1'b0;
            req_done  <= req_grant;
            req_err   <= PSlavErr | ~cmpl;
            req_rdata <= (cmpl && !PSlavErr && !Read_write) ? readOut : '0;
          end
        end
        DONE: begin
          state     <= IDLE;
          req_grant <= '0;
        end
        default: begin
          state     <= IDLE;
          req_grant <= '0;
          transfer  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter: a table of request/slave-behaviour vectors
// with hand-computed outcomes, plus hand-written reset sequences.
module tb_apb_req_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 33;
  localparam int DW   = 32;

  logic               pclk;
  logic               preset;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_grant;
  logic [NREQ-1:0]    req_done;
  logic               req_err;
  logic [DW-1:0]      req_rdata;
  logic               transfer;
  logic               Read_write;
  logic [AW-1:0]      write_addr;
  logic [AW-1:0]      read_addr;
  logic [DW-1:0]      write_data;
  logic               psel;
  logic               penable;
  logic               pready;
  logic [DW-1:0]      readOut;
  logic               PSlavErr;

  apb_req_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(8)) dut (
    .pclk(pclk), .preset(preset),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_grant(req_grant), .req_done(req_done),
    .req_err(req_err), .req_rdata(req_rdata),
    .transfer(transfer), .Read_write(Read_write),
    .write_addr(write_addr), .read_addr(read_addr), .write_data(write_data),
    .psel(psel), .penable(penable), .pready(pready),
    .readOut(readOut), .PSlavErr(PSlavErr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  write;
    int          waits;     // access-phase wait states before pready (99 = never)
    logic        serr;      // PSlavErr high from the access phase on
    logic [31:0] rd;        // value presented on readOut
    int          idx;       // expected winner
    int          ticks;     // expected XFER cycles
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t        vt[16];
  logic [32:0] addr_tab[4];
  logic [31:0] wdata_tab[4];

  int n_vec;
  int n_checks;
  int n_fail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".grant"}, 64'(req_grant), 64'd0);
    chk({tag, ".done"}, 64'(req_done), 64'd0);
    chk({tag, ".err"}, 64'(req_err), 64'd0);
    chk({tag, ".rdata"}, 64'(req_rdata), 64'd0);
    chk({tag, ".transfer"}, 64'(transfer), 64'd0);
    chk({tag, ".rw"}, 64'(Read_write), 64'd0);
    chk({tag, ".waddr"}, 64'(write_addr), 64'd0);
    chk({tag, ".raddr"}, 64'(read_addr), 64'd0);
    chk({tag, ".wdata"}, 64'(write_data), 64'd0);
  endtask

  task automatic bus_idle();
    psel = 1'b0; penable = 1'b0; pready = 1'b0; PSlavErr = 1'b0;
  endtask

  task automatic run_vec(input int n, input vec_t v);
    int lat;
    int ticks;
    int c;
    logic [31:0] exp_wd;
    string tg;
    tg = $sformatf("v%0d", n);
    req_valid = v.valid;
    req_write = v.write;
    readOut   = v.rd;
    lat = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      lat++;
      if (req_grant != '0) break;
    end
    chk({tg, ".grant_lat"}, 64'(lat), 64'd1);
    chk({tg, ".grant"}, 64'(req_grant), 64'(4'b0001 << v.idx));
    exp_wd = v.write[v.idx] ? wdata_tab[v.idx] : 32'h0;
    ticks = 0;
    c = 1;
    for (int k = 0; k < 20; k++) begin
      chk({tg, ".transfer"}, 64'(transfer), 64'd1);
      chk({tg, ".rw"}, 64'(Read_write), 64'(v.write[v.idx]));
      chk({tg, ".waddr"}, 64'(write_addr), 64'(addr_tab[v.idx]));
      chk({tg, ".raddr"}, 64'(read_addr), 64'(addr_tab[v.idx]));
      chk({tg, ".wdata"}, 64'(write_data), 64'(exp_wd));
      psel     = 1'b1;
      penable  = (c >= 2);
      pready   = (c == 2 + v.waits);
      PSlavErr = v.serr && (c >= 2);
      tick();
      ticks++;
      if (req_done != '0) break;
      c++;
    end
    chk({tg, ".xfer_cycles"}, 64'(ticks), 64'(v.ticks));
    chk({tg, ".done"}, 64'(req_done), 64'(4'b0001 << v.idx));
    chk({tg, ".err"}, 64'(req_err), 64'(v.err));
    chk({tg, ".rdata"}, 64'(req_rdata), 64'(v.rdata));
    chk({tg, ".done_transfer"}, 64'(transfer), 64'd0);
    chk({tg, ".done_grant"}, 64'(req_grant), 64'(4'b0001 << v.idx));
    bus_idle();
    tick();
    chk({tg, ".idle_grant"}, 64'(req_grant), 64'd0);
    chk({tg, ".idle_done"}, 64'(req_done), 64'd0);
    chk({tg, ".idle_transfer"}, 64'(transfer), 64'd0);
    chk({tg, ".held_rdata"}, 64'(req_rdata), 64'(v.rdata));
    n_vec++;
  endtask

  initial begin
    n_vec = 0; n_checks = 0; n_fail = 0;
    addr_tab[0]  = 33'h0_1000_0004; wdata_tab[0] = 32'hA5A5_5A5A;
    addr_tab[1]  = 33'h0_0000_0040; wdata_tab[1] = 32'h1111_1111;
    addr_tab[2]  = 33'h0_2000_0080; wdata_tab[2] = 32'h2222_2222;
    addr_tab[3]  = 33'h1_0000_00C0; wdata_tab[3] = 32'h3333_3333;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW]  = addr_tab[i];
      req_wdata[i*DW +: DW] = wdata_tab[i];
    end

    //              valid    write    waits serr  readOut        idx ticks err  rdata
    vt[0]  = '{4'b0101, 4'b0000, 1,  1'b0, 32'h0BAD_F00D, 0, 3, 1'b0, 32'h0BAD_F00D};
    vt[1]  = '{4'b0010, 4'b0000, 2,  1'b0, 32'hDEAD_BEEF, 1, 4, 1'b0, 32'hDEAD_BEEF};
    vt[2]  = '{4'b1000, 4'b1000, 5,  1'b1, 32'hCAFE_0001, 3, 2, 1'b1, 32'h0};
    vt[3]  = '{4'b1111, 4'b1111, 0,  1'b0, 32'h0000_0003, 0, 2, 1'b0, 32'h0};
    vt[4]  = '{4'b1111, 4'b1111, 0,  1'b0, 32'h0000_0004, 1, 2, 1'b0, 32'h0};
    vt[5]  = '{4'b1111, 4'b1111, 0,  1'b0, 32'h0000_0005, 2, 2, 1'b0, 32'h0};
    vt[6]  = '{4'b1111, 4'b1111, 0,  1'b0, 32'h0000_0006, 3, 2, 1'b0, 32'h0};
    vt[7]  = '{4'b1111, 4'b1111, 0,  1'b0, 32'h0000_0007, 0, 2, 1'b0, 32'h0};
    vt[8]  = '{4'b0101, 4'b0101, 0,  1'b0, 32'h0000_0008, 2, 2, 1'b0, 32'h0};
    vt[9]  = '{4'b0101, 4'b0101, 1,  1'b0, 32'h0000_0009, 0, 3, 1'b0, 32'h0};
    vt[10] = '{4'b0101, 4'b0101, 0,  1'b0, 32'h0000_000A, 2, 2, 1'b0, 32'h0};
    vt[11] = '{4'b0010, 4'b0000, 99, 1'b0, 32'h5555_AAAA, 1, 8, 1'b1, 32'h0};
    vt[12] = '{4'b0010, 4'b0000, 6,  1'b0, 32'h1234_5678, 1, 8, 1'b0, 32'h1234_5678};
    vt[13] = '{4'b0001, 4'b0001, 3,  1'b0, 32'hFFFF_FFFF, 0, 5, 1'b0, 32'h0};
    vt[14] = '{4'b0001, 4'b0000, 0,  1'b0, 32'h7777_0000, 0, 2, 1'b0, 32'h7777_0000};
    vt[15] = '{4'b0100, 4'b0000, 0,  1'b1, 32'h9999_9999, 2, 2, 1'b1, 32'h0};

    preset = 1'b1;
    req_valid = '0; req_write = '0; readOut = '0;
    bus_idle();
    tick();
    tick();
    chk_all_zero("reset");
    preset = 1'b0;
    tick();

    // req 2 write in flight, then reset lands mid-cycle
    req_valid = 4'b0100;
    req_write = 4'b0100;
    tick();
    chk("rst_seq.grant", 64'(req_grant), 64'(4'b0100));
    chk("rst_seq.transfer", 64'(transfer), 64'd1);
    chk("rst_seq.waddr", 64'(write_addr), 64'(addr_tab[2]));
    psel = 1'b1;
    tick();
    #3;
    preset = 1'b1;
    #1;
    chk_all_zero("async_rst");
    req_valid = '0;
    bus_idle();
    tick();
    chk("async_rst.no_done", 64'(req_done), 64'd0);
    chk("async_rst.state", 64'(transfer), 64'd0);
    preset = 1'b0;
    tick();
    chk("post_rst.idle", 64'(req_grant), 64'd0);

    for (int i = 0; i < 16; i++) run_vec(i, vt[i]);

    req_valid = '0;
    tick();
    tick();
    chk("final.grant", 64'(req_grant), 64'd0);
    chk("final.transfer", 64'(transfer), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_req_arbiter.md
# apb_req_arbiter

Round-robin arbiter and sequencer that shares the single APB master among `NREQ` independent requesters. It owns the master's command inputs: `transfer`, `Read_write`, `write_addr`, `read_addr` and `write_data`. It watches the APB bus for completion, error or timeout, and returns a one-cycle done/err/rdata response to whichever requester holds the grant.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `AW`, 33: address width; bit 32 is the master's deselect bit, passed through untouched.
- `DW`, 32: data width.
- `TIMEOUT`, 255: maximum XFER cycles before abort (1..255); counter is 8 bits.

Ports (clock and reset first):
- `pclk`  in  1  clock; all state changes on the rising edge.
- `preset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester request.
- `req_write`  in  NREQ  per-requester direction: 1 = write, 0 = read.
- `req_addr`  in  NREQ*AW  packed addresses; requester i occupies bits [i*AW +: AW].
- `req_wdata`  in  NREQ*DW  packed write data; requester i occupies bits [i*DW +: DW].
- `req_grant`  out  NREQ  one-hot grant, held from capture through the DONE cycle.
- `req_done`  out  NREQ  one-hot, one-cycle completion pulse.
- `req_err`  out  1  valid with `req_done`; 1 = slave error or timeout.
- `req_rdata`  out  DW  read data; valid with `req_done`, held until the next done.
- `transfer`  out  1  transfer request to the master.
- `Read_write`  out  1  direction to the master.
- `write_addr`  out  AW  address to the master.
- `read_addr`  out  AW  address to the master.
- `write_data`  out  DW  write data to the master.
- `psel`, `penable`, `pready`  in  1  APB bus observation.
- `readOut`  in  DW  master read-data output.
- `PSlavErr`  in  1  master error flag.

## Operation
- States: IDLE, XFER, DONE. All outputs are registered.
- **IDLE**
  - `transfer` = 0.
  - If any `req_valid` bit is set, select the winner by searching from `last+1` upward, wrapping modulo NREQ.
  - At the edge: capture the winner's write, addr and wdata; set `req_grant`; set `last` = winner; go to XFER.
  - `req_valid` is sampled only in IDLE. Requests arriving in XFER or DONE wait.
- **XFER**
  - `transfer` = 1.
  - `Read_write`, `write_addr` and `read_addr` are driven from the captured request.
  - `write_data` = captured wdata for writes, 0 for reads.
  - The payload is stable for the whole state. The requester may drop `req_valid` after the grant.
- **Completion**: `psel & penable & pready` sampled at an XFER edge. At that edge:
  - `req_err` <= `PSlavErr`.
  - `req_rdata` <= `readOut` for a read without error, otherwise 0.
  - Go to DONE.
- **Error**: `PSlavErr` = 1 at any XFER edge without completion. At that edge: abort, `req_err` <= 1, `req_rdata` <= 0, go to DONE.
- **Timeout**
  - `tcnt` clears on entry to XFER and increments every XFER cycle.
  - If `tcnt == TIMEOUT-1` with neither completion nor error, abort with `req_err` = 1 and `req_rdata` = 0, then go to DONE.
- **Priority at the same edge**: completion beats timeout; `PSlavErr` always sets err.
- **DONE** (one cycle)
  - `transfer` = 0.
  - `req_done[winner]` = 1 and `req_grant` stays set.
  - Next state is IDLE, where `req_grant` clears.
- The arbiter ignores bus activity outside XFER, including the master's trailing setup cycle after `transfer` falls.

## Timing
- **Reset (async, immediate)**: state = IDLE, `last` = NREQ-1 so requester 0 has first priority, `tcnt` = 0. Every output is 0: `req_grant`, `req_done`, `req_err`, `req_rdata`, `transfer`, `Read_write`, `write_addr`, `read_addr`, `write_data`.
- **Reset mid-XFER**: the transaction is dropped with no done pulse. `transfer` falls asynchronously.
- **Request to transfer**: `req_valid` seen at IDLE edge N gives `req_grant` and `transfer` high in cycle N+1.
- **Completion to done**: completion at edge M gives `req_done` high in cycle M+1 (DONE). `transfer` is low in M+1.
- **Back-to-back requests**: the next grant comes no earlier than the edge ending the IDLE cycle after DONE, so minimum spacing between `transfer` pulses is 2 low cycles.
- **Pointer wrap**: `last` = NREQ-1 searches 0, 1, and upward. A sole requester equal to `last` is regranted.

## Test plan
- **Reset values**: assert `preset` mid-XFER (req 2 write in flight) → all outputs 0 asynchronously, no `req_done`; after release a req 0 read is granted first.
- **Single read**: req 1 read, addr 0x0_0000_0040; slave inserts 2 wait states; `readOut` = 0xDEADBEEF → `read_addr` = 0x40, `Read_write` = 0; `req_done` = 0010 one cycle after the completion edge; `req_err` = 0; `req_rdata` = 0xDEADBEEF.
- **Round-robin**: all four requesters held valid for writes → grant order 0, 1, 2, 3, 0. Requests 0 and 2 only, starting with `last` = 0 → order 2, 0, 2.
- **Slave error**: req 3 write with `PSlavErr` forced high in XFER → `req_done` = 1000, `req_err` = 1, `req_rdata` = 0, `transfer` low in DONE.
- **Timeout**: `TIMEOUT` = 8, `pready` stuck low → exactly 8 XFER cycles, then DONE with `req_err` = 1. Variant: `pready` arrives on the 8th cycle → `req_err` = 0.
- **Write payload**: req 0 write, addr 0x0_1000_0004, data 0xA5A5_5A5A → `write_addr` and `write_data` match and stay stable throughout XFER; `req_rdata` = 0 at done.
